// File: rtl/mathb_pkg.sv
// Shared types and constants for the eFPGA-side math-block TPRAM sequencer.
package mathb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // EFPGA_MATHB_DATAOUT_SEL encodings
    localparam logic [1:0] MODE_X32 = 2'b00;
    localparam logic [1:0] MODE_X16 = 2'b01;
    localparam logic [1:0] MODE_X8  = 2'b10;
    localparam logic [1:0] MODE_X4  = 2'b11;

    localparam logic [1:0] DEFPIN_TPRAM = 2'b10;

endpackage

// File: rtl/mathb_seq_addr_gen.sv
// TPRAM read-address generator: loads a base, then steps by 1 (or by a latched
// stride when MATHB_SEQ_STRIDE_EN is defined), wrapping at 2**ADDR_W.
module mathb_seq_addr_gen #(
    parameter int ADDR_W = 9
) (
    input  logic              EFPGA2MATHB_CLK,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    input  logic              step,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] inc;

`ifdef MATHB_SEQ_STRIDE_EN
    logic [ADDR_W-1:0] stride_reg;

    always_ff @(posedge EFPGA2MATHB_CLK) begin
        if (reset) begin
            stride_reg <= '0;
        end else if (load) begin
            stride_reg <= stride;
        end
    end

    assign inc = stride_reg;
`else
    logic unused_stride;

    assign unused_stride = ^stride;
    assign inc           = ADDR_W'(1);
`endif

    // Natural overflow of the adder gives the silent wrap.
    always_ff @(posedge EFPGA2MATHB_CLK) begin
        if (reset) begin
            addr_reg <= '0;
        end else if (load) begin
            addr_reg <= base;
        end else if (step) begin
            addr_reg <= addr_reg + inc;
        end
    end

    assign addr = addr_reg;

endmodule

// File: rtl/mathb_tpram_seq.sv
// Sequencer feeding the math block from operand/coefficient TPRAMs and returning
// the MAC result over valid/ready. Optional stride: define MATHB_SEQ_STRIDE_EN.
module mathb_tpram_seq #(
    parameter int ADDR_W  = 9,
    parameter int LEN_W   = 9,
    parameter int RD_LAT  = 1,
    parameter int MAC_LAT = 2
) (
    input  logic              EFPGA2MATHB_CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [ADDR_W-1:0] cfg_oper_base,
    input  logic [ADDR_W-1:0] cfg_coef_base,
    input  logic [1:0]        cfg_mode,
    input  logic              cfg_tc,
    input  logic [ADDR_W-1:0] cfg_stride,
    output logic              busy,
    output logic [ADDR_W-1:0] oper_raddr,
    output logic [ADDR_W-1:0] coef_raddr,
    output logic              tpram_ren,
    output logic [1:0]        EFPGA_MATHB_OPER_defPin,
    output logic [1:0]        EFPGA_MATHB_COEF_defPin,
    output logic              EFPGA_MATHB_CLK_EN,
    output logic              EFPGA_MATHB_MAC_ACC_CLEAR,
    output logic [1:0]        EFPGA_MATHB_DATAOUT_SEL,
    output logic              EFPGA_MATHB_TC_defPin,
    input  logic [31:0]       FMATHB_EFPGA_MAC_OUT,
    output logic [31:0]       rslt_data,
    output logic              rslt_valid,
    input  logic              rslt_ready
);
    import mathb_pkg::*;

    localparam int DRAIN_CYC = RD_LAT + MAC_LAT;
    localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);

    seq_state_t        state_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  issue_cnt_reg;
    logic [DRAIN_W-1:0] drain_cnt_reg;
    logic [RD_LAT-1:0] en_sr_reg;
    logic [RD_LAT-1:0] clr_sr_reg;
    logic [1:0]        sel_reg;
    logic              tc_reg;
    logic [31:0]       rslt_data_reg;
    logic              rslt_valid_reg;

    logic accept;
    logic issue;
    logic first_issue;

    assign accept      = (state_reg == ST_IDLE) && start;
    assign issue       = (state_reg == ST_ISSUE);
    assign first_issue = issue && (issue_cnt_reg == '0);

    always_ff @(posedge EFPGA2MATHB_CLK) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            len_reg        <= '0;
            issue_cnt_reg  <= '0;
            drain_cnt_reg  <= '0;
            sel_reg        <= MODE_X32;
            tc_reg         <= 1'b0;
            rslt_data_reg  <= '0;
            rslt_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        len_reg       <= cfg_len;
                        sel_reg       <= cfg_mode;
                        tc_reg        <= cfg_tc;
                        issue_cnt_reg <= '0;
                        // An empty job skips straight to a zero result.
                        if (cfg_len == '0) begin
                            rslt_data_reg  <= '0;
                            rslt_valid_reg <= 1'b1;
                            state_reg      <= ST_DONE;
                        end else begin
                            state_reg <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    issue_cnt_reg <= issue_cnt_reg + LEN_W'(1);
                    if (issue_cnt_reg == len_reg - LEN_W'(1)) begin
                        drain_cnt_reg <= '0;
                        state_reg     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt_reg <= drain_cnt_reg + DRAIN_W'(1);
                    // Last sample has cleared both the TPRAM and the MAC pipeline.
                    if (drain_cnt_reg == DRAIN_W'(DRAIN_CYC - 1)) begin
                        rslt_data_reg  <= FMATHB_EFPGA_MAC_OUT;
                        rslt_valid_reg <= 1'b1;
                        state_reg      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rslt_ready) begin
                        rslt_valid_reg <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Issue strobe and first-issue flag delayed to line up with R_DATA at the MAC.
    always_ff @(posedge EFPGA2MATHB_CLK) begin
        if (reset) begin
            en_sr_reg  <= '0;
            clr_sr_reg <= '0;
        end else begin
            en_sr_reg  <= (en_sr_reg << 1) | RD_LAT'(issue);
            clr_sr_reg <= (clr_sr_reg << 1) | RD_LAT'(first_issue);
        end
    end

    mathb_seq_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_oper_addr (
        .EFPGA2MATHB_CLK (EFPGA2MATHB_CLK),
        .reset           (reset),
        .load            (accept),
        .base            (cfg_oper_base),
        .stride          (cfg_stride),
        .step            (issue),
        .addr            (oper_raddr)
    );

    mathb_seq_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_coef_addr (
        .EFPGA2MATHB_CLK (EFPGA2MATHB_CLK),
        .reset           (reset),
        .load            (accept),
        .base            (cfg_coef_base),
        .stride          (cfg_stride),
        .step            (issue),
        .addr            (coef_raddr)
    );

    assign busy                      = (state_reg != ST_IDLE);
    assign tpram_ren                 = issue;
    assign EFPGA_MATHB_OPER_defPin   = DEFPIN_TPRAM;
    assign EFPGA_MATHB_COEF_defPin   = DEFPIN_TPRAM;
    assign EFPGA_MATHB_CLK_EN        = en_sr_reg[RD_LAT-1];
    assign EFPGA_MATHB_MAC_ACC_CLEAR = clr_sr_reg[RD_LAT-1];
    assign EFPGA_MATHB_DATAOUT_SEL   = sel_reg;
    assign EFPGA_MATHB_TC_defPin     = tc_reg;
    assign rslt_data                 = rslt_data_reg;
    assign rslt_valid                = rslt_valid_reg;

endmodule

// File: tb/tb_mathb_tpram_seq.sv
// Randomised bench for mathb_tpram_seq with a TPRAM/MAC environment and a job-level reference model.
module tb_mathb_tpram_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  cfg_len;
    logic [8:0]  cfg_oper_base;
    logic [8:0]  cfg_coef_base;
    logic [1:0]  cfg_mode;
    logic        cfg_tc;
    logic [8:0]  cfg_stride;
    logic        busy;
    logic [8:0]  oper_raddr;
    logic [8:0]  coef_raddr;
    logic        tpram_ren;
    logic [1:0]  oper_defpin;
    logic [1:0]  coef_defpin;
    logic        clk_en;
    logic        acc_clear;
    logic [1:0]  dataout_sel;
    logic        tc_defpin;
    logic [31:0] mac_out;
    logic [31:0] rslt_data;
    logic        rslt_valid;
    logic        rslt_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_jobs   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    mathb_tpram_seq dut (
        .EFPGA2MATHB_CLK           (clk),
        .reset                     (reset),
        .start                     (start),
        .cfg_len                   (cfg_len),
        .cfg_oper_base             (cfg_oper_base),
        .cfg_coef_base             (cfg_coef_base),
        .cfg_mode                  (cfg_mode),
        .cfg_tc                    (cfg_tc),
        .cfg_stride                (cfg_stride),
        .busy                      (busy),
        .oper_raddr                (oper_raddr),
        .coef_raddr                (coef_raddr),
        .tpram_ren                 (tpram_ren),
        .EFPGA_MATHB_OPER_defPin   (oper_defpin),
        .EFPGA_MATHB_COEF_defPin   (coef_defpin),
        .EFPGA_MATHB_CLK_EN        (clk_en),
        .EFPGA_MATHB_MAC_ACC_CLEAR (acc_clear),
        .EFPGA_MATHB_DATAOUT_SEL   (dataout_sel),
        .EFPGA_MATHB_TC_defPin     (tc_defpin),
        .FMATHB_EFPGA_MAC_OUT      (mac_out),
        .rslt_data                 (rslt_data),
        .rslt_valid                (rslt_valid),
        .rslt_ready                (rslt_ready)
    );

    // Environment: two TPRAMs with one-cycle registered read and a MAC with two-cycle latency.
    logic [31:0] oper_mem [512];
    logic [31:0] coef_mem [512];
    logic [31:0] oper_rd = '0;
    logic [31:0] coef_rd = '0;
    logic [31:0] acc     = '0;

    always @(posedge clk) begin
        if (tpram_ren) begin
            oper_rd <= oper_mem[oper_raddr];
            coef_rd <= coef_mem[coef_raddr];
        end
        if (clk_en) acc <= (acc_clear ? 32'd0 : acc) + oper_rd * coef_rd;
        mac_out <= acc;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int step_of(input logic [8:0] stride);
`ifdef MATHB_SEQ_STRIDE_EN
        return int'(stride);
`else
        return (stride == 9'd0) ? 1 : 1;
`endif
    endfunction

    function automatic logic [31:0] ref_mac(input int len, input int ob, input int cb, input int inc);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < len; i++)
            s += oper_mem[(ob + i * inc) & 511] * coef_mem[(cb + i * inc) & 511];
        return s;
    endfunction

    // Job-level reference model and per-cycle compare.
    bit          m_act = 1'b0;
    int          m_t0, m_len, m_ob, m_cb, m_inc, m_vt;
    logic [31:0] m_res;
    logic [1:0]  m_sel = 2'b00;
    logic        m_tc  = 1'b0;

    initial begin
        int  k;
        bit  e_busy, e_ren, e_en, e_clr, e_val;
        forever begin
            @(negedge clk);
            k      = cyc - m_t0;
            e_busy = m_act && k >= 1;
            e_ren  = m_act && k >= 1 && k <= m_len;
            e_en   = m_act && k >= 2 && k <= m_len + 1;
            e_clr  = m_act && k == 2 && m_len >= 1;
            e_val  = m_act && k >= m_vt;
            if (chk_en) begin
                chk("busy", {31'd0, busy}, {31'd0, e_busy});
                chk("tpram_ren", {31'd0, tpram_ren}, {31'd0, e_ren});
                chk("clk_en", {31'd0, clk_en}, {31'd0, e_en});
                chk("acc_clear", {31'd0, acc_clear}, {31'd0, e_clr});
                chk("rslt_valid", {31'd0, rslt_valid}, {31'd0, e_val});
                chk("dataout_sel", {30'd0, dataout_sel}, {30'd0, m_sel});
                chk("tc_defpin", {31'd0, tc_defpin}, {31'd0, m_tc});
                if (e_ren) begin
                    chk("oper_raddr", {23'd0, oper_raddr}, 32'((m_ob + (k - 1) * m_inc) & 511));
                    chk("coef_raddr", {23'd0, coef_raddr}, 32'((m_cb + (k - 1) * m_inc) & 511));
                end
                if (e_val) chk("rslt_data", rslt_data, m_res);
            end
            if (reset) begin
                m_act = 1'b0;
                m_sel = 2'b00;
                m_tc  = 1'b0;
            end else if (m_act && e_val && rslt_ready) begin
                m_act = 1'b0;
            end else if (!m_act && start) begin
                m_act = 1'b1;
                m_t0  = cyc;
                m_len = int'(cfg_len);
                m_ob  = int'(cfg_oper_base);
                m_cb  = int'(cfg_coef_base);
                m_inc = step_of(cfg_stride);
                m_vt  = (m_len == 0) ? 1 : m_len + 4;
                m_res = ref_mac(m_len, m_ob, m_cb, m_inc);
                m_sel = cfg_mode;
                m_tc  = cfg_tc;
            end
            cyc++;
        end
    end

    task automatic run_job(input logic [8:0] len, input logic [8:0] ob, input logic [8:0] cb,
                           input logic [1:0] mode, input logic tc, input logic [8:0] stride,
                           input int rdy_dly, input bit hold_start,
                           input bit do_lit, input int lit_lat, input logic [31:0] lit_data);
        int lat;
        bit got;
        cfg_len = len; cfg_oper_base = ob; cfg_coef_base = cb;
        cfg_mode = mode; cfg_tc = tc; cfg_stride = stride;
        start = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            start         = hold_start || ($urandom_range(0, 3) == 0);
            cfg_len       = 9'($urandom);
            cfg_oper_base = 9'($urandom);
            cfg_coef_base = 9'($urandom);
            cfg_mode      = 2'($urandom);
            cfg_tc        = 1'($urandom);
            cfg_stride    = 9'($urandom);
            if (rslt_valid) got = 1'b1;
        end
        if (!got) begin
            chk("result_timeout", 32'(lat), 32'(lit_lat));
            start = 1'b0;
            return;
        end
        if (do_lit) begin
            chk("latency", 32'(lat), 32'(lit_lat));
            chk("result_literal", rslt_data, lit_data);
        end
        $display("job %0d: len=%0d oper_base=0x%03h coef_base=0x%03h data=0x%08h latency=%0d",
                 n_jobs, len, ob, cb, rslt_data, lat);
        n_jobs++;
        repeat (rdy_dly) begin
            @(posedge clk); #1;
            start = hold_start || ($urandom_range(0, 1) == 0);
        end
        start      = 1'b0;
        rslt_ready = 1'b1;
        @(posedge clk); #1;
        rslt_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            oper_mem[i] = $urandom;
            coef_mem[i] = $urandom;
        end
        reset = 1'b1; start = 1'b0; rslt_ready = 1'b0;
        cfg_len = '0; cfg_oper_base = '0; cfg_coef_base = '0;
        cfg_mode = '0; cfg_tc = 1'b0; cfg_stride = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ren", {31'd0, tpram_ren}, 32'd0);
        chk("rst_clk_en", {31'd0, clk_en}, 32'd0);
        chk("rst_valid", {31'd0, rslt_valid}, 32'd0);
        chk("rst_data", rslt_data, 32'd0);
        chk("rst_oper_addr", {23'd0, oper_raddr}, 32'd0);
        chk("oper_defpin", {30'd0, oper_defpin}, 32'd2);
        chk("coef_defpin", {30'd0, coef_defpin}, 32'd2);
        chk_en = 1'b1;

        // x32 unsigned dot product
        for (int i = 0; i < 4; i++) begin
            oper_mem[9'h020 + i] = 32'(i + 1);
            coef_mem[9'h040 + i] = 32'(i + 5);
        end
        run_job(9'd4, 9'h020, 9'h040, 2'b00, 1'b0, 9'd1, 0, 1'b0, 1'b1, 8, 32'd70);

        // two's-complement result
        oper_mem[9'h030] = -32'sd3; oper_mem[9'h031] = 32'd2;
        coef_mem[9'h050] = 32'd4;   coef_mem[9'h051] = 32'd5;
        run_job(9'd2, 9'h030, 9'h050, 2'b00, 1'b1, 9'd1, 0, 1'b0, 1'b1, 6, 32'hFFFF_FFFE);

        // back-to-back with ready withheld and start held high during DONE
        run_job(9'd4, 9'h020, 9'h040, 2'b01, 1'b0, 9'd1, 5, 1'b1, 1'b1, 8, 32'd70);
        run_job(9'd2, 9'h030, 9'h050, 2'b10, 1'b1, 9'd1, 0, 1'b0, 1'b1, 6, 32'hFFFF_FFFE);

        // empty job
        run_job(9'd0, 9'h000, 9'h000, 2'b11, 1'b0, 9'd1, 2, 1'b0, 1'b1, 1, 32'd0);

        // address wrap
        oper_mem[9'h1FE] = 32'd2; oper_mem[9'h1FF] = 32'd3;
        oper_mem[9'h000] = 32'd4; oper_mem[9'h001] = 32'd5;
        coef_mem[9'h1FE] = 32'd1; coef_mem[9'h1FF] = 32'd1;
        coef_mem[9'h000] = 32'd1; coef_mem[9'h001] = 32'd1;
        run_job(9'd4, 9'h1FE, 9'h1FE, 2'b00, 1'b0, 9'd1, 1, 1'b0, 1'b1, 8, 32'd14);

        // stride
        for (int i = 0; i < 5; i++) coef_mem[9'h010 + i] = 32'd1;
        oper_mem[9'h010] = 32'd1;    oper_mem[9'h011] = 32'd10;
        oper_mem[9'h012] = 32'd100;  oper_mem[9'h013] = 32'd1000;
        oper_mem[9'h014] = 32'd10000;
`ifdef MATHB_SEQ_STRIDE_EN
        run_job(9'd3, 9'h010, 9'h010, 2'b00, 1'b0, 9'd2, 0, 1'b0, 1'b1, 7, 32'd10101);
`else
        run_job(9'd3, 9'h010, 9'h010, 2'b00, 1'b0, 9'd2, 0, 1'b0, 1'b1, 7, 32'd111);
`endif

        // reset during ISSUE aborts the job
        cfg_len = 9'd4; cfg_oper_base = 9'h1FE; cfg_coef_base = 9'h1FE; cfg_stride = 9'd1;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_clk_en", {31'd0, clk_en}, 32'd0);
        chk("abort_valid", {31'd0, rslt_valid}, 32'd0);
        // start and reset together: reset wins
        start = 1'b1; reset = 1'b1;
        @(posedge clk); #1 start = 1'b0; reset = 1'b0;
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        repeat (8) @(posedge clk);
        #1 chk("abort_no_result", {31'd0, rslt_valid}, 32'd0);

        // randomised jobs
        for (int j = 0; j < 30; j++) begin
            run_job(9'($urandom_range(0, 16)), 9'($urandom), 9'($urandom), 2'($urandom),
                    1'($urandom), 9'($urandom_range(0, 5)), $urandom_range(0, 4),
                    1'b0, 1'b0, 0, 32'd0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
